byte_pack_buffer: RTL and testbench

- Sits directly downstream of the keep-masking stage.
- Accepts its registered output bus (`busoutvld`/`busoutkeep`/`busout`), compacts the kept bytes and appends them to a circular byte store.
- Drains the store as a ready/valid byte bus.
- Returns the free-space count (`bytesavailout`) that drives the masking stage's `bytesavailin`, closing the credit loop.

---
 rtl/byte_pack_buffer_pkg.sv | 38 +++
 rtl/byte_pack_buffer_if.sv | 25 ++
 rtl/byte_pack_buffer_compact.sv | 27 ++
 rtl/byte_pack_buffer.sv | 150 +++++++++++++++
 tb/tb_byte_pack_buffer.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/byte_pack_buffer_pkg.sv
// Shared widths, types and helpers for the byte pack buffer.
// Bus width and store depth are fixed here; every block derives its widths from them.
package byte_pack_pkg;

  localparam int BUSBYTEWIDTH = 16;
  localparam int BYTESAVAIL   = 32;

  localparam int DATA_W = BUSBYTEWIDTH * 8;
  localparam int PTR_W  = $clog2(BYTESAVAIL);
  localparam int OCC_W  = PTR_W + 1;
  localparam int CNT_W  = $clog2(BUSBYTEWIDTH + 1);

  // Largest value bytesavailout can report.
  localparam logic [PTR_W-1:0] AVAIL_MAX = '1;

  typedef logic [BUSBYTEWIDTH-1:0] keep_t;
  typedef logic [DATA_W-1:0]       data_t;
  typedef logic [CNT_W-1:0]        cnt_t;

  function automatic cnt_t popcount(input keep_t v);
    cnt_t acc;
    acc = '0;
    for (int i = 0; i < BUSBYTEWIDTH; i++) begin
      acc = acc + cnt_t'(v[i]);
    end
    return acc;
  endfunction

  function automatic keep_t keep_lowmask(input cnt_t n);
    keep_t mask;
    mask = '0;
    for (int i = 0; i < BUSBYTEWIDTH; i++) begin
      mask[i] = (i < int'(n));
    end
    return mask;
  endfunction

endpackage

// File: rtl/byte_pack_buffer_if.sv
// Byte bus between the keep-masking stage, the pack buffer and its consumer.
// The master side drives input beats and downstream ready; the slave side is the buffer.
interface byte_pack_buffer_if;
  import byte_pack_pkg::*;

  logic  businvld;
  keep_t businkeep;
  data_t busin;

  logic  busoutvld;
  logic  busoutrdy;
  keep_t busoutkeep;
  data_t busout;

  modport master (
    output businvld, businkeep, busin, busoutrdy,
    input  busoutvld, busoutkeep, busout
  );

  modport slave (
    input  businvld, businkeep, busin, busoutrdy,
    output busoutvld, busoutkeep, busout
  );

endinterface

// File: rtl/byte_pack_buffer_compact.sv
// Combinational lane compactor: moves kept lanes down into the low lanes in
// ascending lane order and reports how many bytes were kept.
module byte_compact
  import byte_pack_pkg::*;
(
  input  keep_t keep,
  input  data_t data,
  output data_t packed_data,
  output cnt_t  count
);

  // NOTE: every combinational output gets a default before the loop, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    int unsigned idx;
    packed_data = '0;
    idx         = 0;
    for (int k = 0; k < BUSBYTEWIDTH; k++) begin
      if (keep[k]) begin
        packed_data[idx*8 +: 8] = data[k*8 +: 8];
        idx = idx + 1;
      end
    end
  end

  assign count = popcount(keep);

endmodule

// File: rtl/byte_pack_buffer.sv
// Compacts kept input bytes into a circular byte store and drains it as a ready/valid byte bus.
// Define BYTE_PACK_FULL_WORD_EN to emit only full BUSBYTEWIDTH-byte beats.
module byte_pack_buffer
  import byte_pack_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  byte_pack_buffer_if.slave    bus,
  output logic [PTR_W-1:0]     bytesavailout,
  output logic                 overflow
);

  logic  s1_vld;
  keep_t s1_keep;
  data_t s1_data;

  data_t c_data;
  cnt_t  c_cnt;
  data_t s2_data;
  cnt_t  s2_cnt;

  logic [7:0]       mem [BYTESAVAIL];
  logic [PTR_W-1:0] wrptr, rdptr;
  logic [OCC_W-1:0] occ;

  logic  out_vld;
  keep_t out_keep;
  data_t out_data;

  // NOTE: clocked state uses non-blocking assignments so every register samples start-of-cycle values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_vld  <= 1'b0;
      s1_keep <= '0;
      s1_data <= '0;
    end else begin
      s1_vld  <= bus.businvld;
      s1_keep <= bus.businkeep;
      s1_data <= bus.busin;
    end
  end

  // Invalid beats compact to nothing; the count doubles as the S1 lookahead.
  byte_compact u_compact (
    .keep        (s1_vld ? s1_keep : '0),
    .data        (s1_data),
    .packed_data (c_data),
    .count       (c_cnt)
  );

  logic [OCC_W-1:0] free_bytes;
  logic             wr_en;
  logic             out_ready;
  logic             loadable;
  logic             load;
  cnt_t             load_n;
  data_t            load_data;
  logic [OCC_W-1:0] inflight;
  logic [PTR_W-1:0] avail_next;

  assign free_bytes = OCC_W'(BYTESAVAIL) - occ;
  // Whole-beat accept against start-of-cycle space; bytes freed by a same-cycle load wait a cycle.
  assign wr_en      = (OCC_W'(s2_cnt) <= free_bytes);
  assign out_ready  = !out_vld || bus.busoutrdy;

`ifdef BYTE_PACK_FULL_WORD_EN
  assign loadable = (occ >= OCC_W'(BUSBYTEWIDTH));
`else
  assign loadable = (occ != '0);
`endif

  assign load   = out_ready && loadable;
  assign load_n = (occ > OCC_W'(BUSBYTEWIDTH)) ? cnt_t'(BUSBYTEWIDTH) : cnt_t'(occ);

  always_comb begin
    load_data = '0;
    for (int i = 0; i < BUSBYTEWIDTH; i++) begin
      if (i < int'(load_n)) begin
        load_data[i*8 +: 8] = mem[rdptr + PTR_W'(i)];
      end
    end
  end

  // Bytes still in S1/S2 are charged against free space so the upstream credit stays conservative.
  assign inflight = OCC_W'(c_cnt) + OCC_W'(s2_cnt);

  always_comb begin
    logic [OCC_W-1:0] diff;
    diff       = '0;
    avail_next = '0;
    if (inflight < free_bytes) begin
      diff       = free_bytes - inflight;
      avail_next = (diff > OCC_W'(AVAIL_MAX)) ? AVAIL_MAX : diff[PTR_W-1:0];
    end
  end

  // NOTE: the byte store is deliberately not reset; pointers and occupancy alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < BUSBYTEWIDTH; i++) begin
        if (i < int'(s2_cnt)) begin
          mem[wrptr + PTR_W'(i)] <= s2_data[i*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_data       <= '0;
      s2_cnt        <= '0;
      wrptr         <= '0;
      rdptr         <= '0;
      occ           <= '0;
      overflow      <= 1'b0;
      out_vld       <= 1'b0;
      out_keep      <= '0;
      out_data      <= '0;
      bytesavailout <= AVAIL_MAX;
    end else begin
      s2_data <= c_data;
      s2_cnt  <= c_cnt;

      if (wr_en) begin
        wrptr <= wrptr + PTR_W'(s2_cnt);
      end else begin
        overflow <= 1'b1;
      end

      if (load) begin
        rdptr    <= rdptr + PTR_W'(load_n);
        out_vld  <= 1'b1;
        out_keep <= keep_lowmask(load_n);
        out_data <= load_data;
      end else if (out_ready) begin
        out_vld  <= 1'b0;
        out_keep <= '0;
        out_data <= '0;
      end

      occ <= occ + (wr_en ? OCC_W'(s2_cnt) : '0) - (load ? OCC_W'(load_n) : '0);
      bytesavailout <= avail_next;
    end
  end

  assign bus.busoutvld  = out_vld;
  assign bus.busoutkeep = out_keep;
  assign bus.busout     = out_data;

endmodule

// File: tb/tb_byte_pack_buffer.sv
// Self-checking bench for byte_pack_buffer: a queue-based scoreboard predicts every
// output beat, the free-space count and the overflow flag on each clock edge.
module tb_byte_pack_buffer;
  import byte_pack_pkg::*;

`ifdef BYTE_PACK_FULL_WORD_EN
  localparam int LOAD_MIN = BUSBYTEWIDTH;
`else
  localparam int LOAD_MIN = 1;
`endif
  localparam int AVAIL_CAP = (1 << PTR_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic [PTR_W-1:0] bytesavailout;
  logic             overflow;

  byte_pack_buffer_if bus ();

  byte_pack_buffer dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .bytesavailout (bytesavailout),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  int    checks   = 0;
  int    failures = 0;
  string phase    = "init";

  task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s.%s: got %0h expected %0h", phase, tag, got, exp);
    end
  endtask

  // Scoreboard: kept bytes enter m_s1_q when driven and flow stage by stage to m_out_q.
  logic [7:0] m_s1_q[$];
  logic [7:0] m_s2_q[$];
  logic [7:0] m_store_q[$];
  logic [7:0] m_out_q[$];
  bit         m_out_vld;
  bit         m_ovf;
  int         m_avail;
  logic [7:0] seq = 8'h00;

  task automatic model_reset();
    m_s1_q    = {};
    m_s2_q    = {};
    m_store_q = {};
    m_out_q   = {};
    m_out_vld = 1'b0;
    m_ovf     = 1'b0;
    m_avail   = AVAIL_CAP;
  endtask

  task automatic model_edge(input logic vld, input keep_t keep, input data_t data, input logic rdy);
    int occ;
    int space;
    int av;
    int n;
    occ   = m_store_q.size();
    space = BYTESAVAIL - occ;
    av    = space - m_s1_q.size() - m_s2_q.size();
    if (av < 0) av = 0;
    if (av > AVAIL_CAP) av = AVAIL_CAP;
    if (!m_out_vld || rdy) begin
      m_out_q = {};
      if (occ >= LOAD_MIN) begin
        n = (occ < BUSBYTEWIDTH) ? occ : BUSBYTEWIDTH;
        for (int i = 0; i < n; i++) m_out_q.push_back(m_store_q.pop_front());
        m_out_vld = 1'b1;
      end else begin
        m_out_vld = 1'b0;
      end
    end
    if (m_s2_q.size() <= space) begin
      foreach (m_s2_q[i]) m_store_q.push_back(m_s2_q[i]);
    end else begin
      m_ovf = 1'b1;
    end
    m_s2_q = m_s1_q;
    m_s1_q = {};
    if (vld) begin
      for (int k = 0; k < BUSBYTEWIDTH; k++) begin
        if (keep[k]) m_s1_q.push_back(data[k*8 +: 8]);
      end
    end
    m_avail = av;
  endtask

  task automatic compare_outputs();
    data_t exp_data;
    keep_t exp_keep;
    exp_data = '0;
    exp_keep = '0;
    foreach (m_out_q[i]) begin
      exp_data[i*8 +: 8] = m_out_q[i];
      exp_keep[i]        = 1'b1;
    end
    check("busoutvld", DATA_W'(bus.busoutvld), DATA_W'(m_out_vld));
    check("busoutkeep", DATA_W'(bus.busoutkeep), DATA_W'(exp_keep));
    check("busout", bus.busout, exp_data);
    check("bytesavailout", DATA_W'(bytesavailout), DATA_W'(m_avail));
    check("overflow", DATA_W'(overflow), DATA_W'(m_ovf));
  endtask

  // Inputs change at posedge+1; outputs are compared at posedge+1 after the model steps.
  task automatic cycle(input logic vld, input keep_t keep, input data_t data, input logic rdy);
    bus.businvld  = vld;
    bus.businkeep = keep;
    bus.busin     = data;
    bus.busoutrdy = rdy;
    @(posedge clk);
    model_edge(vld, keep, data, rdy);
    #1;
    compare_outputs();
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, rdy);
  endtask

  // Kept lanes carry a running byte sequence; dropped lanes carry random junk.
  task automatic make_beat(input keep_t keep, output data_t d);
    for (int k = 0; k < BUSBYTEWIDTH; k++) begin
      if (keep[k]) begin
        d[k*8 +: 8] = seq;
        seq         = seq + 8'd1;
      end else begin
        d[k*8 +: 8] = 8'($urandom);
      end
    end
  endtask

  task automatic send(input keep_t keep, input logic rdy);
    data_t d;
    make_beat(keep, d);
    cycle(1'b1, keep, d, rdy);
  endtask

  // Asynchronous reset between edges; outputs must clear before the next edge.
  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    #1;
    compare_outputs();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    data_t lanes;
    reset         = 1'b0;
    bus.businvld  = 1'b0;
    bus.businkeep = '0;
    bus.busin     = '0;
    bus.busoutrdy = 1'b0;
    model_reset();

    phase = "reset";
    #12;
    compare_outputs();
    check("avail31", DATA_W'(bytesavailout), DATA_W'(31));
    reset = 1'b1;

`ifndef BYTE_PACK_FULL_WORD_EN
    phase = "sparse";
    for (int k = 0; k < BUSBYTEWIDTH; k++) lanes[k*8 +: 8] = 8'(k);
    cycle(1'b1, 16'h8421, lanes, 1'b0);
    idle(3, 1'b0);
    check("vld_n3", DATA_W'(bus.busoutvld), DATA_W'(1));
    check("keep_n3", DATA_W'(bus.busoutkeep), DATA_W'(16'h000F));
    check("lanes_n3", bus.busout, DATA_W'(32'h0F0A_0500));
    idle(3, 1'b1);
`endif

    phase = "wrap";
    do_reset();
    send(16'hFFFF, 1'b0);
    send(16'h00FF, 1'b0);
    idle(4, 1'b0);
    idle(1, 1'b1);
    idle(3, 1'b0);
    send(16'hFFFF, 1'b0);
    send(16'hFFFF, 1'b0);
    send(16'hFFFF, 1'b0);
    idle(4, 1'b0);
`ifndef BYTE_PACK_FULL_WORD_EN
    check("ovf_set", DATA_W'(overflow), DATA_W'(1));
`endif
    idle(10, 1'b1);

    phase = "overflow";
    do_reset();
    for (int i = 0; i < 4; i++) send(16'hFFFF, 1'b0);
    idle(4, 1'b0);
`ifndef BYTE_PACK_FULL_WORD_EN
    check("ovf_full", DATA_W'(overflow), DATA_W'(1));
    check("avail_full", DATA_W'(bytesavailout), DATA_W'(0));
`endif
    idle(8, 1'b1);

    phase = "backpressure";
    do_reset();
    for (int i = 0; i < 40; i++) send(16'h000F, (i % 2) == 0);
    idle(10, 1'b1);

    phase = "random";
    do_reset();
    for (int i = 0; i < 80; i++) begin
      if (i == 40) begin
        phase = "midreset";
        do_reset();
      end
      if ($urandom_range(3) != 0) send(keep_t'($urandom), 1'($urandom));
      else idle(1, 1'($urandom));
    end
    idle(12, 1'b1);

`ifdef BYTE_PACK_FULL_WORD_EN
    phase = "fullword";
    do_reset();
    send(16'h03FF, 1'b1);
    idle(5, 1'b1);
    check("partial_held", DATA_W'(bus.busoutvld), DATA_W'(0));
    send(16'h003F, 1'b0);
    idle(4, 1'b0);
    check("full_vld", DATA_W'(bus.busoutvld), DATA_W'(1));
    check("full_keep", DATA_W'(bus.busoutkeep), DATA_W'(16'hFFFF));
    idle(3, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
